// File: rtl/gcd_host_seq.sv
// rtl/gcd_host_seq.sv - request/response sequencer driving the subtractive GCD engine
// Optional GCD_ZERO_BYPASS_EN: zero operands answered directly as A|B without starting the engine.
module gcd_host_seq #(
  parameter int WIDTH          = 16,
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int TCW            = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [WIDTH-1:0] data_in,
  output logic             start,
  input  logic             done,
  input  logic [WIDTH-1:0] gcd_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_gcd,
  output logic             rsp_err,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_A, S_LOAD_B, S_WAIT, S_RESP, S_DRAIN
  } state_t;

  localparam logic [TCW-1:0] TMO = TCW'(TIMEOUT_CYCLES);

  state_t           state, state_next;
  logic [WIDTH-1:0] a_q, b_q;
  logic [TCW-1:0]   wd, wd_inc;
  logic             accept, zero_op, timeout;

  assign accept = req_valid && (state == S_IDLE);

`ifdef GCD_ZERO_BYPASS_EN
  assign zero_op = (req_a == '0) || (req_b == '0);
`else
  assign zero_op = 1'b0;
`endif

  // Timeout fires on the cycle the watchdog reaches its limit, so WAIT lasts exactly TIMEOUT_CYCLES.
  assign wd_inc  = (wd == TMO) ? wd : wd + 1'b1;
  assign timeout = (wd_inc == TMO);

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    start      = 1'b0;
    data_in    = '0;
    rsp_valid  = 1'b0;
    busy       = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = zero_op ? S_RESP : S_LOAD_A;
      end
      S_LOAD_A: begin
        start      = 1'b1;
        data_in    = a_q;
        state_next = S_LOAD_B;
      end
      S_LOAD_B: begin
        start      = 1'b1;
        data_in    = b_q;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        start   = 1'b1;
        data_in = b_q;
        if (done || timeout) state_next = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = done ? S_DRAIN : S_IDLE;
      end
      S_DRAIN: begin
        if (!done) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      wd      <= '0;
      rsp_gcd <= '0;
      rsp_err <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        a_q     <= req_a;
        b_q     <= req_b;
        rsp_gcd <= zero_op ? (req_a | req_b) : '0;
        rsp_err <= 1'b0;
      end
      if (state == S_WAIT) begin
        wd <= wd_inc;
        if (done) begin
          rsp_gcd <= gcd_result;
          rsp_err <= 1'b0;
        end else if (timeout) begin
          rsp_gcd <= '0;
          rsp_err <= 1'b1;
        end
      end else if (state_next == S_IDLE) begin
        wd <= '0;
      end
    end
  end

endmodule

// File: doc/gcd_host_seq.md
Name: gcd_host_seq

Overview:
Initiator-side sequencer for the subtractive GCD engine (datapath plus controller pair). It accepts an operand pair over a valid/ready request port and drives the engine's shared serial data_in bus: A first, then B, with start held. It waits for done, captures the result, and returns it over a valid/ready response port. A watchdog reports engines that hang.

Parameters:
WIDTH, 16, operand/result width; matches the engine data_in width
TIMEOUT_CYCLES, 1023, max cycles in WAIT before an error response; must be ≥ 1
TCW, 10, watchdog counter width; requires 2^TCW > TIMEOUT_CYCLES

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  operand pair offered
req_ready  output  1  sequencer can accept a pair
req_a  input  WIDTH  operand A
req_b  input  WIDTH  operand B
data_in  output  WIDTH  serial operand bus to the engine
start  output  1  engine start, level
done  input  1  engine done, level
gcd_result  input  WIDTH  engine A register output, valid while done=1
rsp_valid  output  1  response available
rsp_ready  input  1  consumer accepts response
rsp_gcd  output  WIDTH  GCD result; 0 on error
rsp_err  output  1  1 = timeout, result invalid
busy  output  1  1 in any state other than IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE; req_ready=1, start=0, data_in=0, rsp_valid=0, rsp_gcd=0, rsp_err=0, busy=0, watchdog=0. Reset mid-operation aborts immediately. No response is produced for an aborted request.
- req_ready=1 only in IDLE. The request is accepted on the edge where req_valid&&req_ready; A and B are latched internally.
- IDLE -> LOAD_A on accept.
- LOAD_A (1 cycle): start=1, data_in=A. Always -> LOAD_B.
- LOAD_B (1 cycle): start=1, data_in=B. Always -> WAIT.
- WAIT: start=1, data_in holds B, watchdog increments each cycle.
  - done=1 -> capture gcd_result into rsp_gcd, rsp_err=0, -> RESP.
  - watchdog == TIMEOUT_CYCLES with done=0 -> rsp_gcd=0, rsp_err=1, -> RESP.
  - done and timeout in the same cycle: done wins.
- RESP: start=0, rsp_valid=1. rsp_gcd and rsp_err stay stable until the handshake.
  - rsp_ready=1 -> rsp_valid=0 next cycle, -> DRAIN. rsp_ready already high on entry means a 1-cycle response.
- DRAIN: start=0. Waits for done=0, then -> IDLE, with watchdog cleared.
  - DRAIN is skipped straight to IDLE when done is already 0.
  - On the timeout path, DRAIN also waits for done=0. This keeps a late done from contaminating the next request.
- Latency with an engine needing N cycles from B-load to done: rsp_valid rises N+3 cycles after the accept edge.
- data_in is 0 in IDLE, RESP and DRAIN.
- busy=1 in every non-IDLE state.
- No arithmetic in the sequencer. The watchdog saturates at TIMEOUT_CYCLES.
- req_valid while busy: ignored (req_ready=0). The upstream must hold the request.

Optional Feature:
Macro GCD_ZERO_BYPASS_EN.
- Defined: at accept, if A==0 or B==0, go IDLE -> RESP directly.
  - rsp_gcd = A|B, i.e. gcd(0,x)=x and gcd(0,0)=0; rsp_err=0.
  - start is never asserted, which avoids the subtractive engine hanging on zero operands.
  - Response latency is 1 cycle after accept.
- Not defined: zero operands go to the engine unchanged and normally terminate via timeout with rsp_err=1.

Test Plan:
1. Basic pair: A=143, B=78 with a behavioural engine model.
   - data_in shows 143 in LOAD_A, then 78 in LOAD_B.
   - rsp_valid rises with rsp_gcd=13, rsp_err=0; start falls in RESP.
2. Back-to-back with backpressure: (48,18) then (17,5), with rsp_ready held low for 4 cycles.
   - rsp_gcd=6 holds stable for the 4 cycles; req_ready stays 0 until DRAIN exits.
   - The second request then yields 1.
3. Hung engine: done tied 0.
   - After exactly TIMEOUT_CYCLES cycles in WAIT: rsp_valid=1, rsp_err=1, rsp_gcd=0.
4. Simultaneous events: done asserted on the same cycle the watchdog reaches TIMEOUT_CYCLES -> rsp_err=0 with the captured result.
5. Reset mid-WAIT: rst_n pulsed low during (1000,10).
   - All outputs return to their reset values asynchronously; no rsp_valid.
   - Next request (9,6) -> 3.
6. With GCD_ZERO_BYPASS_EN: (0,25) -> rsp_gcd=25 one cycle after accept, start never high; (0,0) -> 0. Without the macro: (0,25) -> rsp_err=1 after timeout.
